bus_arbiter3: RTL and testbench

Three-requester round-robin arbiter for the RV523 shared memory bus. It grants the bus to the fetch unit, the load/store unit, or the debug port, and holds each grant for one transfer, or for several when the requester locks it. Between owners it inserts one dead cycle, so the tri-state bus drivers always break before they make. A watchdog forcibly revokes any grant whose transfer never completes.

---
 rtl/rv523_arb_pkg.sv | 31 +++
 rtl/rr_pick3.sv | 50 +++++
 rtl/bus_arbiter3.sv | 126 ++++++++++++
 tb/tb_bus_arbiter3.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv523_arb_pkg.sv
// Shared types and constants for the RV523 three-requester bus arbiter.
package rv523_arb_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned IDX_W   = 2;

    // Requester indices on the req/lock/gnt vectors
    localparam logic [IDX_W-1:0] REQ_FETCH = 2'd0;
    localparam logic [IDX_W-1:0] REQ_LSU   = 2'd1;
    localparam logic [IDX_W-1:0] REQ_DBG   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DEAD  = 2'd2
    } arb_state_t;

    // Index to one-hot grant vector; an out-of-range index yields no grant
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        case (idx)
            REQ_FETCH: oh = 3'b001;
            REQ_LSU:   oh = 3'b010;
            REQ_DBG:   oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Round-robin selector: first active request after 'last', with 'last' itself lowest.
module rr_pick3
    import rv523_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] w_c0;
    logic [IDX_W-1:0] w_c1;
    logic [IDX_W-1:0] w_c2;

    // Candidate order last+1, last+2, last (mod 3); unexpected 'last' behaves like DBG
    always_comb begin
        w_c0 = REQ_FETCH;
        w_c1 = REQ_LSU;
        w_c2 = REQ_DBG;
        case (last)
            REQ_FETCH: begin
                w_c0 = REQ_LSU;
                w_c1 = REQ_DBG;
                w_c2 = REQ_FETCH;
            end
            REQ_LSU: begin
                w_c0 = REQ_DBG;
                w_c1 = REQ_FETCH;
                w_c2 = REQ_LSU;
            end
            default: begin
                w_c0 = REQ_FETCH;
                w_c1 = REQ_LSU;
                w_c2 = REQ_DBG;
            end
        endcase
    end

    // Take the first candidate whose request is set
    always_comb begin
        valid = |req;
        idx   = w_c2;
        if (|(req & idx_to_onehot(w_c0))) begin
            idx = w_c0;
        end else if (|(req & idx_to_onehot(w_c1))) begin
            idx = w_c1;
        end
    end

endmodule

// File: rtl/bus_arbiter3.sv
// RV523 shared-bus arbiter: round-robin grant, optional lock, dead cycle between owners,
// and a watchdog that revokes grants whose transfer never completes.
module bus_arbiter3
    import rv523_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic               bus_done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   owner,
    output logic               busy,
    output logic               to_err,
    output logic [IDX_W-1:0]   to_src
);

    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam bit          WD_EN   = (TIMEOUT > 0);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_owner;
    logic               r_busy;
    logic               r_to_err;
    logic [IDX_W-1:0]   r_to_src;
    logic [CNT_W-1:0]   r_count;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_own_req;
    logic               w_own_lock;
    logic               w_to_hit;

    // Shared picker; r_owner as 'last' makes the released owner lowest priority
    rr_pick3 u_pick (
        .req   (req),
        .last  (r_owner),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // In GRANT the grant vector is one-hot on the owner, so it masks the owner's bits
    assign w_own_req  = |(req  & r_gnt);
    assign w_own_lock = |(lock & r_gnt);
    assign w_to_hit   = WD_EN && (r_count == CNT_W'(TO_LAST));

    // Arbiter FSM with registered grant, owner, watchdog and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_owner  <= REQ_DBG;
            r_busy   <= 1'b0;
            r_to_err <= 1'b0;
            r_to_src <= REQ_FETCH;
            r_count  <= '0;
        end else begin
            r_to_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= GRANT;
                        r_gnt   <= idx_to_onehot(w_pick_idx);
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                    end
                end
                GRANT: begin
                    if (!w_own_req) begin
                        // owner abandoned its request
                        r_state <= DEAD;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else if (bus_done && w_own_lock) begin
                        // locked follow-on transfer: keep the bus, restart the watchdog
                        r_count <= '0;
                    end else if (bus_done) begin
                        r_state <= DEAD;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else if (w_to_hit) begin
                        r_state  <= DEAD;
                        r_gnt    <= '0;
                        r_busy   <= 1'b0;
                        r_count  <= '0;
                        r_to_err <= 1'b1;
                        r_to_src <= r_owner;
                    end else if (WD_EN) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                DEAD: begin
                    if (w_pick_valid) begin
                        r_state <= GRANT;
                        r_gnt   <= idx_to_onehot(w_pick_idx);
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign busy   = r_busy;
    assign to_err = r_to_err;
    assign to_src = r_to_src;

endmodule

// File: tb/tb_bus_arbiter3.sv
// Directed bench for bus_arbiter3 with a 4-cycle watchdog.
module tb_bus_arbiter3;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] lock;
    logic       bus_done;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       to_err;
    logic [1:0] to_src;

    int n_total;
    int n_bad;

    bus_arbiter3 #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .bus_done (bus_done),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .to_err   (to_err),
        .to_src   (to_src)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        req      = 3'b000;
        lock     = 3'b000;
        bus_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if ({gnt, owner, busy, to_err, to_src} !== {3'b000, 2'd2, 1'b0, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_state got gnt=%b owner=%0d busy=%b to_err=%b to_src=%0d want 000/2/0/0/0",
                     gnt, owner, busy, to_err, to_src);
        end
        // bus_done with nobody on the bus changes nothing
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        tick();
        n_total++;
        if ({gnt, busy} !== {3'b000, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_done got gnt=%b busy=%b want 000/0", gnt, busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 3'b001;
        tick();
        n_total++;
        if ({gnt, owner, busy} !== {3'b001, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL single_grant got gnt=%b owner=%0d busy=%b want 001/0/1", gnt, owner, busy);
        end
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        req      = 3'b000;
        n_total++;
        if ({gnt, busy} !== {3'b000, 1'b0}) begin
            n_bad++;
            $display("FAIL single_release got gnt=%b busy=%b want 000/0", gnt, busy);
        end
        tick();
        tick();
        n_total++;
        if ({gnt, owner, busy} !== {3'b000, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL single_idle got gnt=%b owner=%0d busy=%b want 000/0/0", gnt, owner, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b100;
        exp_seq[3] = 3'b001;
        apply_reset();
        req = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) begin
                n_total++;
                if (gnt !== exp_seq[i]) begin
                    n_bad++;
                    $display("FAIL rr_grant[%0d] cyc%0d got gnt=%b want %b", i, c, gnt, exp_seq[i]);
                end
                if (c == 2) bus_done = 1'b1;
                tick();
            end
            bus_done = 1'b0;
            n_total++;
            if (gnt !== 3'b000) begin
                n_bad++;
                $display("FAIL rr_dead[%0d] got gnt=%b want 000", i, gnt);
            end
            tick();
        end
    endtask

    task automatic test_lock();
        apply_reset();
        req = 3'b010;
        tick();
        lock = 3'b010;
        req  = 3'b111;
        for (int p = 0; p < 3; p++) begin
            bus_done = 1'b1;
            tick();
            bus_done = 1'b0;
            n_total++;
            if ({gnt, owner} !== {3'b010, 2'd1}) begin
                n_bad++;
                $display("FAIL lock_hold[%0d] got gnt=%b owner=%0d want 010/1", p, gnt, owner);
            end
            tick();
            n_total++;
            if (gnt !== 3'b010) begin
                n_bad++;
                $display("FAIL lock_hold2[%0d] got gnt=%b want 010", p, gnt);
            end
        end
        lock     = 3'b000;
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        n_total++;
        if (gnt !== 3'b000) begin
            n_bad++;
            $display("FAIL lock_release got gnt=%b want 000", gnt);
        end
        tick();
        n_total++;
        if ({gnt, owner} !== {3'b100, 2'd2}) begin
            n_bad++;
            $display("FAIL lock_next got gnt=%b owner=%0d want 100/2", gnt, owner);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        req = 3'b100;
        tick();
        for (int c = 0; c < 4; c++) begin
            n_total++;
            if ({gnt, to_err} !== {3'b100, 1'b0}) begin
                n_bad++;
                $display("FAIL to_hold cyc%0d got gnt=%b to_err=%b want 100/0", c, gnt, to_err);
            end
            if (c < 3) tick();
        end
        tick();
        n_total++;
        if ({gnt, busy, to_err, to_src} !== {3'b000, 1'b0, 1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL to_fire got gnt=%b busy=%b to_err=%b to_src=%0d want 000/0/1/2",
                     gnt, busy, to_err, to_src);
        end
        tick();
        n_total++;
        if ({gnt, to_err, to_src} !== {3'b100, 1'b0, 2'd2}) begin
            n_bad++;
            $display("FAIL to_regrant_same got gnt=%b to_err=%b to_src=%0d want 100/0/2", gnt, to_err, to_src);
        end
        req = 3'b101;
        tick();
        tick();
        tick();
        tick();
        n_total++;
        if ({gnt, to_err} !== {3'b000, 1'b1}) begin
            n_bad++;
            $display("FAIL to_fire2 got gnt=%b to_err=%b want 000/1", gnt, to_err);
        end
        tick();
        n_total++;
        if ({gnt, owner, to_err, to_src} !== {3'b001, 2'd0, 1'b0, 2'd2}) begin
            n_bad++;
            $display("FAIL to_regrant_other got gnt=%b owner=%0d to_err=%b to_src=%0d want 001/0/0/2",
                     gnt, owner, to_err, to_src);
        end
    endtask

    task automatic test_done_vs_timeout();
        apply_reset();
        req = 3'b010;
        tick();
        tick();
        tick();
        tick();
        n_total++;
        if (gnt !== 3'b010) begin
            n_bad++;
            $display("FAIL dvt_pre got gnt=%b want 010", gnt);
        end
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        n_total++;
        if ({gnt, to_err, to_src} !== {3'b000, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL dvt_release got gnt=%b to_err=%b to_src=%0d want 000/0/0", gnt, to_err, to_src);
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        req = 3'b010;
        tick();
        n_total++;
        if ({gnt, owner} !== {3'b010, 2'd1}) begin
            n_bad++;
            $display("FAIL rmid_pre got gnt=%b owner=%0d want 010/1", gnt, owner);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({gnt, owner, busy, to_err} !== {3'b000, 2'd2, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rmid_async got gnt=%b owner=%0d busy=%b to_err=%b want 000/2/0/0",
                     gnt, owner, busy, to_err);
        end
        tick();
        rst_n = 1'b1;
        req   = 3'b000;
        tick();
    endtask

    task automatic test_abort();
        apply_reset();
        req = 3'b011;
        tick();
        tick();
        n_total++;
        if (gnt !== 3'b001) begin
            n_bad++;
            $display("FAIL abort_pre got gnt=%b want 001", gnt);
        end
        req = 3'b010;
        tick();
        n_total++;
        if ({gnt, busy, to_err} !== {3'b000, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_drop got gnt=%b busy=%b to_err=%b want 000/0/0", gnt, busy, to_err);
        end
        tick();
        n_total++;
        if ({gnt, owner, busy} !== {3'b010, 2'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_next got gnt=%b owner=%0d busy=%b want 010/1/1", gnt, owner, busy);
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        req      = 3'b000;
        lock     = 3'b000;
        bus_done = 1'b0;
        n_total  = 0;
        n_bad    = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_done_vs_timeout();
        test_reset_mid_grant();
        test_abort();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
